// File: rtl/wb_writer_pkg.sv
// Shared constants and helpers for the write-back stage.
// Pulled in by wb_writer and wb_scoreboard.
package wb_writer_pkg;

  localparam int NUM_REGS  = 8;
  localparam int REG_SEL_W = 3;
  localparam int DATA_W    = 16;

  localparam logic [1:0] WBSEL_ALU = 2'b00;
  localparam logic [1:0] WBSEL_MEM = 2'b01;
  localparam logic [1:0] WBSEL_PC  = 2'b10;
  localparam logic [1:0] WBSEL_ILL = 2'b11;

  // Pick the write-back source. The illegal encoding produces zero so that
  // nothing stale ever leaks onto the register-file data bus.
  function automatic logic [DATA_W-1:0] wb_select(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] rdata,
    input logic [DATA_W-1:0] pcinc
  );
    logic [DATA_W-1:0] res;
    case (sel)
      WBSEL_ALU: res = alu;
      WBSEL_MEM: res = rdata;
      WBSEL_PC:  res = pcinc;
      default:   res = {DATA_W{1'b0}};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write scoreboard: one saturating up/down counter per
// architectural register. Issue increments, retire decrements; an issue and
// retire hitting the same register in one cycle cancel out.
// err_evt pulses for one cycle on overflow or underflow; the caller holds
// the sticky flag.
module wb_scoreboard
  import wb_writer_pkg::*;
#(
  parameter int SB_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_en,
  input  logic [REG_SEL_W-1:0] inc_sel,
  input  logic                 dec_en,
  input  logic [REG_SEL_W-1:0] dec_sel,
  output logic [NUM_REGS-1:0]  busy,
  output logic                 err_evt
);

  localparam logic [SB_BITS-1:0] CNT_MAX  = {SB_BITS{1'b1}};
  localparam logic [SB_BITS-1:0] CNT_ZERO = {SB_BITS{1'b0}};
  localparam logic [SB_BITS-1:0] CNT_ONE  = {{(SB_BITS-1){1'b0}}, 1'b1};

  logic [SB_BITS-1:0]  cnt_q [NUM_REGS];
  logic [SB_BITS-1:0]  cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                err_s;

  // Next-state counters, busy vector and overflow/underflow detection.
  always_comb begin
    err_s = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      logic inc_hit;
      logic dec_hit;
      inc_hit  = inc_en && (inc_sel == r[REG_SEL_W-1:0]);
      dec_hit  = dec_en && (dec_sel == r[REG_SEL_W-1:0]);
      cnt_d[r] = cnt_q[r];
      if (inc_hit && dec_hit) begin
        cnt_d[r] = cnt_q[r];
      end else if (inc_hit) begin
        if (cnt_q[r] == CNT_MAX) begin
          err_s = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        end
      end else if (dec_hit) begin
        if (cnt_q[r] == CNT_ZERO) begin
          err_s = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNT_ONE;
        end
      end else begin
        cnt_d[r] = cnt_q[r];
      end
      busy_d[r] = (cnt_d[r] != CNT_ZERO);
    end
  end

  // Counter and busy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= CNT_ZERO;
      end
      busy_q <= {NUM_REGS{1'b0}};
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign err_evt = err_s;

endmodule

// File: rtl/wb_writer.sv
// Write-back stage: MEM/WB pipeline latch, source select, register-file
// write port, sticky error flag and (optionally) the pending-write
// scoreboard. Define WB_SCOREBOARD_EN to build the scoreboard; without it
// busy is tied low, the iss_* inputs are ignored and err only reports the
// illegal source select.
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int SB_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  input  logic                 iss_regwrite,
  input  logic [REG_SEL_W-1:0] iss_dst,
  input  logic                 mem_valid,
  input  logic                 mem_regwrite,
  input  logic                 mem_kill,
  input  logic [REG_SEL_W-1:0] mem_dst,
  input  logic [1:0]           mem_wbsel,
  input  logic [DATA_W-1:0]    mem_alu,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic [DATA_W-1:0]    mem_pcinc,
  output logic [REG_SEL_W-1:0] writeregsel,
  output logic [DATA_W-1:0]    writedata,
  output logic                 write,
  output logic [NUM_REGS-1:0]  busy,
  output logic                 err
);

  logic                 valid_q, valid_d;
  logic                 regwrite_q, regwrite_d;
  logic                 kill_q, kill_d;
  logic [REG_SEL_W-1:0] dst_q, dst_d;
  logic [1:0]           wbsel_q, wbsel_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 err_q, err_d;

  logic                 retire_s;
  logic                 ill_s;
  logic                 write_s;
  logic                 sb_err_s;

  // Next latch contents; the source mux sits ahead of the latch so only the
  // selected word is stored. WB never stalls, so capture is unconditional.
  always_comb begin
    valid_d    = mem_valid;
    regwrite_d = mem_regwrite;
    kill_d     = mem_kill;
    dst_d      = mem_dst;
    wbsel_d    = mem_wbsel;
    data_d     = wb_select(mem_wbsel, mem_alu, mem_rdata, mem_pcinc);
  end

  // Retire / write-enable decode from the latch, and the sticky error update.
  always_comb begin
    retire_s = valid_q & regwrite_q;
    ill_s    = (wbsel_q == WBSEL_ILL);
    write_s  = retire_s & ~kill_q & ~ill_s;
    err_d    = err_q | (retire_s & ill_s) | sb_err_s;
  end

  // MEM/WB latch and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      kill_q     <= 1'b0;
      dst_q      <= {REG_SEL_W{1'b0}};
      wbsel_q    <= WBSEL_ALU;
      data_q     <= {DATA_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      kill_q     <= kill_d;
      dst_q      <= dst_d;
      wbsel_q    <= wbsel_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign write       = write_s;
  assign writeregsel = dst_q;
  assign writedata   = data_q;
  assign err         = err_q;

`ifdef WB_SCOREBOARD_EN
  wb_scoreboard #(
    .SB_BITS (SB_BITS)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .inc_en  (iss_valid & iss_regwrite),
    .inc_sel (iss_dst),
    .dec_en  (retire_s),
    .dec_sel (dst_q),
    .busy    (busy),
    .err_evt (sb_err_s)
  );
`else
  // Issue-side inputs have no consumer in the non-pipelined build.
  logic unused_iss_s;
  assign unused_iss_s = ^{iss_valid, iss_regwrite, iss_dst};
  assign busy         = {NUM_REGS{1'b0}};
  assign sb_err_s     = 1'b0;
`endif

endmodule
